// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, parity codes and a parity helper.
// The receiver path imports the same package.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Zero-extended upper bits do not change the XOR, so narrow frames can use this too.
    function automatic logic parity_of(input logic [7:0] d, input int mode);
        return (mode == PAR_EVEN) ? ^d : ~^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: emits a one-cycle tick every cnt_bit cycles, realigned by restart.
module uart_baud_gen #(
    parameter int cnt_bit = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = (cnt_bit > 1) ? $clog2(cnt_bit) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= CW'(cnt_bit - 1);
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and serialises it
// LSB first as start, data, optional parity and stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int f_clk     = 50_000_000,
    parameter int baudrate  = 100_000,
    parameter int data_bits = 8,
    parameter int parity    = PAR_NONE,
    parameter int stop_bits = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy
);
    localparam int CNT_BIT = f_clk / baudrate;
    localparam int BW      = $clog2(data_bits + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(data_bits - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(stop_bits - 1);

    uart_state_e          state, state_nx;
    logic [data_bits-1:0] shreg;
    logic                 par_bit;
    logic [BW-1:0]        bit_cnt;
    logic                 ready_q;
    logic                 tick, restart, accept, tx_nx;

    assign accept    = bus.valid && ready_q;
    assign bus.ready = ready_q;
    assign busy      = ~ready_q;

    uart_baud_gen #(.cnt_bit(CNT_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // tx_nx is decoded from the current state and registered, so the line
    // trails the state register by one cycle and never glitches.
    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        tx_nx    = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = START;
                    restart  = 1'b1;
                end
            end
            START: begin
                tx_nx = 1'b0;
                if (tick) state_nx = DATA;
            end
            DATA: begin
                tx_nx = shreg[0];
                if (tick && bit_cnt == LAST_DATA)
                    state_nx = (parity != PAR_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                tx_nx = par_bit;
                if (tick) state_nx = STOP;
            end
            STOP: begin
                if (tick && bit_cnt == LAST_STOP) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == IDLE);
            tx      <= tx_nx;
            if (accept) begin
                shreg   <= bus.data;
                par_bit <= parity_of(8'(bus.data), parity);
            end else if (state == DATA && tick) begin
                shreg <= shreg >> 1;
            end
            // bit_cnt counts data bits in DATA and stop bits in STOP
            if (state_nx != state)
                bit_cnt <= '0;
            else if (tick && (state == DATA || state == STOP))
                bit_cnt <= bit_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover default, even/odd parity and
// a 5-bit / 2-stop / fast-baud configuration.
module tb_uart_tx;
    import uart_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dat [4];
    logic       vld [4];
    logic       tx_w [4];
    logic       rdy_w [4];
    logic       bsy_w [4];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(5)) if3 ();

    assign if0.data = dat[0];      assign if0.valid = vld[0];  assign rdy_w[0] = if0.ready;
    assign if1.data = dat[1];      assign if1.valid = vld[1];  assign rdy_w[1] = if1.ready;
    assign if2.data = dat[2];      assign if2.valid = vld[2];  assign rdy_w[2] = if2.ready;
    assign if3.data = dat[3][4:0]; assign if3.valid = vld[3];  assign rdy_w[3] = if3.ready;

    uart_tx u0 (.clk(clk), .rst(rst), .bus(if0), .tx(tx_w[0]), .busy(bsy_w[0]));
    uart_tx #(.parity(PAR_EVEN)) u1 (.clk(clk), .rst(rst), .bus(if1), .tx(tx_w[1]), .busy(bsy_w[1]));
    uart_tx #(.parity(PAR_ODD))  u2 (.clk(clk), .rst(rst), .bus(if2), .tx(tx_w[2]), .busy(bsy_w[2]));
    uart_tx #(.baudrate(1_000_000), .data_bits(5), .stop_bits(2))
        u3 (.clk(clk), .rst(rst), .bus(if3), .tx(tx_w[3]), .busy(bsy_w[3]));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller 1 time unit after the accepting edge, valid still high.
    task automatic send(input int k, input logic [7:0] d, input string tag);
        int t = 0;
        while (!rdy_w[k] && t < 20000) begin
            step();
            t++;
        end
        chk({tag, "_ready_wait"}, int'(rdy_w[k]), 1);
        dat[k] = d;
        vld[k] = 1'b1;
        step();
    endtask

    // Called just after the accepting edge; walks the whole frame cycle by cycle.
    task automatic check_frame(input int k, input logic [7:0] d, input int nb,
                               input int par, input int exp_par, input int stops,
                               input int cnt, input int len, input int pulse_at,
                               input logic [7:0] pulse_d, input string tag);
        logic       bits [16];
        logic [7:0] cap = '0;
        int         n = 0, bad = 0, low = 0, par_seen = -1, b;
        bits[n] = 1'b0; n++;
        for (int j = 0; j < nb; j++) begin bits[n] = d[j]; n++; end
        if (par != 0) begin bits[n] = exp_par[0]; n++; end
        for (int j = 0; j < stops; j++) begin bits[n] = 1'b1; n++; end

        for (int i = 0; i <= len; i++) begin
            if (i > 0) step();
            if (pulse_at > 0 && i == pulse_at) begin dat[k] = pulse_d; vld[k] = 1'b1; end
            if (pulse_at > 0 && i == pulse_at + 1) vld[k] = 1'b0;
            if (!rdy_w[k]) low++;
            if (bsy_w[k] == rdy_w[k]) bad++;
            if (i == 0) begin
                chk({tag, "_tx_before_start"}, int'(tx_w[k]), 1);
            end else begin
                b = (i - 1) / cnt;
                if (tx_w[k] !== bits[b]) bad++;
                if ((i - 1) % cnt == cnt / 2) begin
                    if (b >= 1 && b <= nb) cap[b-1] = tx_w[k];
                    if (par != 0 && b == nb + 1) par_seen = int'(tx_w[k]);
                end
            end
        end
        chk({tag, "_wave_errs"}, bad, 0);
        chk({tag, "_data"}, int'(cap), int'(d));
        chk({tag, "_ready_low"}, low, len);
        if (par != 0) chk({tag, "_parity"}, par_seen, exp_par);
    endtask

    initial begin
        int low;
        for (int k = 0; k < 4; k++) begin dat[k] = '0; vld[k] = 1'b0; end
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx", int'(tx_w[0]), 1);
        chk("rst_ready", int'(rdy_w[0]), 1);
        chk("rst_busy", int'(bsy_w[0]), 0);
        chk("rst_ready_u3", int'(rdy_w[3]), 1);
        rst = 1'b0;
        step();

        // 0x55, default framing
        send(0, 8'h55, "t1");
        vld[0] = 1'b0;
        check_frame(0, 8'h55, 8, 0, 0, 1, 500, 5000, 0, 8'h00, "t1");

        // 0x07 with even then odd parity
        send(1, 8'h07, "t2e");
        vld[1] = 1'b0;
        check_frame(1, 8'h07, 8, 2, 1, 1, 500, 5500, 0, 8'h00, "t2e");
        send(2, 8'h07, "t2o");
        vld[2] = 1'b0;
        check_frame(2, 8'h07, 8, 1, 0, 1, 500, 5500, 0, 8'h00, "t2o");

        // valid held: back-to-back frames, data changed mid-frame
        send(0, 8'hA3, "t3a");
        dat[0] = 8'h3C;
        check_frame(0, 8'hA3, 8, 0, 0, 1, 500, 5000, 0, 8'h00, "t3a");
        step();
        vld[0] = 1'b0;
        check_frame(0, 8'h3C, 8, 0, 0, 1, 500, 5000, 0, 8'h00, "t3b");

        // valid pulsed while busy must be ignored
        send(0, 8'hC6, "t5");
        vld[0] = 1'b0;
        check_frame(0, 8'hC6, 8, 0, 0, 1, 500, 5000, 1000, 8'h99, "t5");
        low = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (!tx_w[0] || !rdy_w[0]) low++;
        end
        chk("t5_no_second_frame", low, 0);

        // reset during data bit 4 of 0xFF
        send(0, 8'hFF, "t4");
        vld[0] = 1'b0;
        repeat (2700) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_tx_after_rst", int'(tx_w[0]), 1);
        chk("t4_ready_after_rst", int'(rdy_w[0]), 1);
        chk("t4_busy_after_rst", int'(bsy_w[0]), 0);
        low = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (!tx_w[0]) low++;
        end
        chk("t4_line_idle", low, 0);
        send(0, 8'h5A, "t4b");
        vld[0] = 1'b0;
        check_frame(0, 8'h5A, 8, 0, 0, 1, 500, 5000, 0, 8'h00, "t4b");

        // rst and valid together: rst wins
        rst = 1'b1;
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        step();
        rst = 1'b0;
        vld[0] = 1'b0;
        chk("rstv_ready", int'(rdy_w[0]), 1);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!tx_w[0] || !rdy_w[0]) low++;
        end
        chk("rstv_no_frame", low, 0);

        // 5 data bits, 2 stop bits, 50-cycle bit
        send(3, 8'h1F, "t6");
        vld[3] = 1'b0;
        check_frame(3, 8'h1F, 5, 0, 0, 2, 50, 400, 0, 8'h00, "t6");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
